// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, datapath mux
// selects and FSM state. MC_JUMP_EN adds the JUMP state.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_J     = 6'd2;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
`ifdef MC_JUMP_EN
        S_JUMP      = 4'd13,
`endif
        S_HALT      = 4'd12
    } state_e;

endpackage

// File: rtl/mc_opcode_class.sv
// Combinational opcode classifier used by DECODE. Under MC_JUMP_EN the jump
// opcode is legal; otherwise it is reported as illegal.
module mc_opcode_class
    import mc_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6
) (
    input  logic [OPCODE_W-1:0] opcode,
    output logic                is_mem,
    output logic                is_lw,
    output logic                is_rtype,
    output logic                is_beq,
    output logic                is_addi,
    output logic                is_j,
    output logic                is_illegal
);

    logic is_sw_s;

    // Opcode match flags; illegal is whatever no supported class claims.
    always_comb begin
        is_lw    = (opcode == OPCODE_W'(OP_LW));
        is_sw_s  = (opcode == OPCODE_W'(OP_SW));
        is_rtype = (opcode == OPCODE_W'(OP_RTYPE));
        is_beq   = (opcode == OPCODE_W'(OP_BEQ));
        is_addi  = (opcode == OPCODE_W'(OP_ADDI));
`ifdef MC_JUMP_EN
        is_j     = (opcode == OPCODE_W'(OP_J));
`else
        is_j     = 1'b0;
`endif
        is_mem     = is_lw | is_sw_s;
        is_illegal = ~(is_mem | is_rtype | is_beq | is_addi | is_j);
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore-FSM main control for the multicycle MIPS datapath, with memory-ready
// stalls, retire counter and sticky illegal-opcode trap. MC_JUMP_EN enables j.
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [1:0]          pc_source,
    output logic                instr_done,
    output logic                illegal_op,
    output logic [CNT_W-1:0]    instr_count
);

`ifdef MC_JUMP_EN
    localparam state_e J_NEXT = S_JUMP;
`else
    localparam state_e J_NEXT = S_HALT;
`endif

    state_e             state_q, state_d;
    logic               is_lw_q, is_lw_d;
    logic               illegal_q, illegal_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               retire_s;
    logic               is_mem_s, is_lw_s, is_rtype_s, is_beq_s, is_addi_s, is_j_s, is_illegal_s;

    mc_opcode_class #(.OPCODE_W(OPCODE_W)) u_class (
        .opcode     (opcode),
        .is_mem     (is_mem_s),
        .is_lw      (is_lw_s),
        .is_rtype   (is_rtype_s),
        .is_beq     (is_beq_s),
        .is_addi    (is_addi_s),
        .is_j       (is_j_s),
        .is_illegal (is_illegal_s)
    );

    // State, load/store flavour, trap flag and retire counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            is_lw_q   <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            is_lw_q   <= is_lw_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state sequencing and retire detection; opcode is only looked at in DECODE.
    always_comb begin
        state_d  = state_q;
        is_lw_d  = is_lw_q;
        retire_s = 1'b0;
        case (state_q)
            S_IDLE:      state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
                else           state_d = S_FETCH;
            end
            S_DECODE: begin
                is_lw_d = is_lw_s;
                if (is_illegal_s)    state_d = S_HALT;
                else if (is_mem_s)   state_d = S_MEM_ADDR;
                else if (is_rtype_s) state_d = S_EXECUTE;
                else if (is_beq_s)   state_d = S_BRANCH;
                else if (is_addi_s)  state_d = S_ADDI_EXEC;
                else if (is_j_s)     state_d = J_NEXT;
                else                 state_d = S_HALT;
            end
            S_MEM_ADDR: begin
                if (is_lw_q) state_d = S_MEM_READ;
                else         state_d = S_MEM_WRITE;
            end
            S_MEM_READ: begin
                if (mem_ready) state_d = S_MEM_WB;
                else           state_d = S_MEM_READ;
            end
            S_MEM_WRITE: begin
                if (mem_ready) begin
                    retire_s = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    state_d  = S_MEM_WRITE;
                end
            end
            S_EXECUTE:   state_d = S_ALU_WB;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_MEM_WB, S_ALU_WB, S_BRANCH, S_ADDI_WB: begin
                retire_s = 1'b1;
                state_d  = S_FETCH;
            end
`ifdef MC_JUMP_EN
            S_JUMP: begin
                retire_s = 1'b1;
                state_d  = S_FETCH;
            end
`endif
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_IDLE;
        endcase
        illegal_d = illegal_q | (state_d == S_HALT);
        cnt_d     = retire_s ? (cnt_q + CNT_W'(1)) : cnt_q;
    end

    // Moore output decode; FETCH alone gates ir_write/pc_write with mem_ready.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        alu_op        = ALU_ADD;
        pc_source     = PCSRC_ALU;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE:    alu_src_b = SRCB_IMM_SH;
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_ALU_WB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
            end
            S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_ADDI_WB:   reg_write = 1'b1;
`ifdef MC_JUMP_EN
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
            end
`endif
            default: begin
                pc_write = 1'b0;
            end
        endcase
    end

    assign instr_done  = retire_s;
    assign illegal_op  = illegal_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the driver walks each instruction
// through its phases and queues expected outputs; monitors compare at negedge.
module tb_multicycle_control;

    localparam int CNT_W = 4;

    localparam int P_RST = 0, P_IDLE = 1, P_FETCH = 2, P_DECODE = 3, P_MADDR = 4,
                   P_MREAD = 5, P_MWB = 6, P_MWRITE = 7, P_EXEC = 8, P_AWB = 9,
                   P_BR = 10, P_AEXEC = 11, P_AIWB = 12, P_JUMP = 13, P_HALT = 14;

    typedef struct packed {
        logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, srca;
        logic [1:0] srcb, aop, pcs;
        logic       done, ill;
    } ctl_t;

    typedef struct {
        ctl_t             ctl;
        logic [CNT_W-1:0] cnt;
        int               ph;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic mem_ready = 1'b0;
    logic pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic instr_done, illegal_op;
    logic [CNT_W-1:0] instr_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int model_cnt = 0;
    exp_t exp_q[$];
    logic [CNT_W-1:0] ret_q[$];

    multicycle_control #(.OPCODE_W(6), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // Expected controls per phase, straight from the control table.
    function automatic ctl_t exp_ctl(input int ph, input logic mr);
        ctl_t c;
        c = '0;
        case (ph)
            P_FETCH:  begin c.mrd = 1'b1; c.srcb = 2'b01; c.irw = mr; c.pcw = mr; end
            P_DECODE: c.srcb = 2'b11;
            P_MADDR:  begin c.srca = 1'b1; c.srcb = 2'b10; end
            P_MREAD:  begin c.mrd = 1'b1; c.iord = 1'b1; end
            P_MWB:    begin c.m2r = 1'b1; c.rwr = 1'b1; c.done = 1'b1; end
            P_MWRITE: begin c.mwr = 1'b1; c.iord = 1'b1; c.done = mr; end
            P_EXEC:   begin c.srca = 1'b1; c.aop = 2'b10; end
            P_AWB:    begin c.rdst = 1'b1; c.rwr = 1'b1; c.done = 1'b1; end
            P_BR:     begin c.srca = 1'b1; c.aop = 2'b01; c.pcwc = 1'b1; c.pcs = 2'b01; c.done = 1'b1; end
            P_AEXEC:  begin c.srca = 1'b1; c.srcb = 2'b10; end
            P_AIWB:   begin c.rwr = 1'b1; c.done = 1'b1; end
            P_JUMP:   begin c.pcw = 1'b1; c.pcs = 2'b10; c.done = 1'b1; end
            P_HALT:   c.ill = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [5:0] ro();
        return 6'($urandom_range(0, 63));
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock of stimulus plus the expectation for that cycle.
    task automatic step(input int ph, input logic r, input logic mr, input logic [5:0] op);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        mem_ready = mr;
        opcode = op;
        if (ph == P_RST) model_cnt = 0;
        e.ctl = exp_ctl(ph, mr);
        e.cnt = CNT_W'(model_cnt);
        e.ph  = ph;
        exp_q.push_back(e);
        if (e.ctl.done) begin
            model_cnt = (model_cnt + 1) % (1 << CNT_W);
            ret_q.push_back(CNT_W'(model_cnt));
        end
    endtask

    task automatic do_reset();
        step(P_RST, 1'b1, rb(), ro());
        step(P_RST, 1'b1, rb(), ro());
        step(P_IDLE, 1'b0, rb(), ro());
    endtask

    task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
        for (int i = 0; i < wf; i++) step(P_FETCH, 1'b0, 1'b0, ro());
        step(P_FETCH, 1'b0, 1'b1, ro());
        step(P_DECODE, 1'b0, rb(), op);
        case (op)
            6'd35: begin
                step(P_MADDR, 1'b0, rb(), ro());
                for (int i = 0; i < wm; i++) step(P_MREAD, 1'b0, 1'b0, ro());
                step(P_MREAD, 1'b0, 1'b1, ro());
                step(P_MWB, 1'b0, rb(), ro());
            end
            6'd43: begin
                step(P_MADDR, 1'b0, rb(), ro());
                for (int i = 0; i < wm; i++) step(P_MWRITE, 1'b0, 1'b0, ro());
                step(P_MWRITE, 1'b0, 1'b1, ro());
            end
            6'd0: begin
                step(P_EXEC, 1'b0, rb(), ro());
                step(P_AWB, 1'b0, rb(), ro());
            end
            6'd8: begin
                step(P_AEXEC, 1'b0, rb(), ro());
                step(P_AIWB, 1'b0, rb(), ro());
            end
            6'd4: step(P_BR, 1'b0, rb(), ro());
`ifdef MC_JUMP_EN
            6'd2: step(P_JUMP, 1'b0, rb(), ro());
`endif
            default: begin
                for (int i = 0; i < 22; i++) step(P_HALT, 1'b0, rb(), ro());
                do_reset();
            end
        endcase
    endtask

    // Per-cycle monitor: every driven cycle has one queued expectation.
    initial begin
        exp_t e;
        ctl_t act;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                       mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                       pc_source, instr_done, illegal_op};
                checks++;
                if (act !== e.ctl) begin
                    errors++;
                    $display("FAIL ctrl cyc=%0d phase=%0d actual=%b required=%b", cyc, e.ph, act, e.ctl);
                end
                checks++;
                if (instr_count !== e.cnt) begin
                    errors++;
                    $display("FAIL count cyc=%0d phase=%0d actual=%0d required=%0d", cyc, e.ph, instr_count, e.cnt);
                end
            end
        end
    end

    // Retire monitor: each instr_done pulse consumes one expected post-retire count.
    initial begin
        logic [CNT_W-1:0] want;
        forever begin
            @(negedge clk);
            if (instr_done === 1'b1) begin
                checks++;
                if (ret_q.size() == 0) begin
                    errors++;
                    $display("FAIL retire_unexpected cyc=%0d actual=1 required=0", cyc);
                end else begin
                    want = ret_q.pop_front();
                    @(negedge clk);
                    if (instr_count !== want) begin
                        errors++;
                        $display("FAIL retire_count actual=%0d required=%0d", instr_count, want);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        do_reset();
        // lw with no wait, then sw with a 3-cycle write stall.
        run_instr(6'd35, 0, 0);
        run_instr(6'd43, 0, 3);
        run_instr(6'd0, 0, 0);
        run_instr(6'd8, 0, 0);
        run_instr(6'd4, 0, 0);
        run_instr(6'd63, 0, 0);
        run_instr(6'd2, 1, 0);
        // Reset during a load stall.
        step(P_FETCH, 1'b0, 1'b1, ro());
        step(P_DECODE, 1'b0, 1'b1, 6'd35);
        step(P_MADDR, 1'b0, 1'b1, ro());
        step(P_MREAD, 1'b0, 1'b0, ro());
        step(P_MREAD, 1'b0, 1'b0, ro());
        do_reset();
        for (int i = 0; i < 17; i++) run_instr(6'd8, 0, 0);
        for (int n = 0; n < 60; n++) begin
            k = $urandom_range(0, 10);
            case (k)
                0, 1:    run_instr(6'd0,  $urandom_range(0, 3), 0);
                2, 3:    run_instr(6'd35, $urandom_range(0, 3), $urandom_range(0, 3));
                4, 5:    run_instr(6'd43, $urandom_range(0, 3), $urandom_range(0, 3));
                6:       run_instr(6'd4,  $urandom_range(0, 3), 0);
                7, 8:    run_instr(6'd8,  $urandom_range(0, 3), 0);
                9:       run_instr(6'd2,  $urandom_range(0, 3), 0);
                default: run_instr(6'd17, $urandom_range(0, 3), 0);
            endcase
        end
        step(P_FETCH, 1'b0, 1'b0, ro());
        step(P_FETCH, 1'b0, 1'b0, ro());
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0 || ret_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d/%0d required=0/0", exp_q.size(), ret_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Next-generation main control unit for the MIPS datapath.
- Replaces single-cycle opcode decode with a Moore FSM that sequences fetch / decode / execute / memory / writeback over several cycles.
- Stalls on a variable-latency memory via a ready handshake.
- Counts retired instructions and traps on unsupported opcodes.
- Sits between the instruction register opcode field and the shared multicycle datapath (PC, IR, register file, ALU, memory port).

Parameters:
- OPCODE_W, 6, opcode field width.
- CNT_W, 32, width of the retired-instruction counter.
- OP_RTYPE, 0, R-type opcode.
- OP_LW, 35, load-word opcode.
- OP_SW, 43, store-word opcode.
- OP_BEQ, 4, branch-equal opcode.
- OP_ADDI, 8, add-immediate opcode.
- OP_J, 2, jump opcode (used only with the optional feature).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  OPCODE_W  IR[31:26]; sampled in DECODE.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a  out  1 each  datapath controls.
- alu_src_b  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
- alu_op  out  2  00=add, 01=sub, 10=funct-decode.
- pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target.
- instr_done  out  1  one-cycle pulse on retire.
- illegal_op  out  1  sticky trap flag.
- instr_count  out  CNT_W  retired-instruction count.

Behaviour:
- Reset: state=IDLE, instr_count=0, illegal_op=0. All outputs 0 while in reset and in IDLE.
- Outputs are decoded purely from state, except that FETCH qualifies ir_write and pc_write with mem_ready.
- Any output not listed for a state is 0.
- IDLE: all outputs 0; next state FETCH.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=mem_ready. Hold while !mem_ready; go to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute). Next state by opcode:
  - lw or sw -> MEM_ADDR
  - R-type -> EXECUTE
  - beq -> BRANCH
  - addi -> ADDI_EXEC
  - j -> JUMP (only if the feature is enabled)
  - any other opcode -> HALT
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_read=1, iord=1. Hold until mem_ready, then MEM_WB.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1; retire; next FETCH.
- MEM_WRITE: mem_write=1, iord=1. Hold until mem_ready, then retire and go to FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10; next ALU_WB.
- ALU_WB: reg_dst=1, reg_write=1, mem_to_reg=0; retire; next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; retire; next FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00; next ADDI_WB.
- ADDI_WB: reg_dst=0, reg_write=1, mem_to_reg=0; retire; next FETCH.
- HALT: all datapath outputs 0; illegal_op set to 1 on entry and held until rst. The only exit is reset.
- Retire: instr_done=1 for exactly the retiring cycle; instr_count increments by 1 in the same cycle.
- instr_count wraps from 2^CNT_W-1 to 0 silently.
- mem_ready is ignored outside FETCH, MEM_READ and MEM_WRITE.
- opcode is sampled only in DECODE; changes in other states have no effect.
- Cycle counts with zero memory wait:
  - lw: 5 cycles
  - sw, R-type, addi: 4 cycles
  - beq, j: 3 cycles
- rst asserted in any state, including mid-stall, returns to IDLE immediately. Outputs drop to 0 asynchronously and no partial write is issued afterwards.

Optional Feature:
- Macro MC_JUMP_EN.
- Defined: opcode OP_J at DECODE goes to JUMP. JUMP drives pc_write=1, pc_source=10, retires and returns to FETCH.
- Undefined: the JUMP state does not exist and OP_J is treated as illegal (goes to HALT).

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum
  - opcode localparams
  - alu_op encodings ALU_ADD/ALU_SUB/ALU_FUNCT
  - alu_src_b encodings SRCB_REG/SRCB_FOUR/SRCB_IMM/SRCB_IMM_SH
  - pc_source encodings
- One natural sub-module: mc_opcode_class, a combinational opcode classifier producing is_mem/is_lw/is_rtype/is_beq/is_addi/is_j/is_illegal. DECODE uses it to select the next state.
- The FSM, output decode and counter stay in multicycle_control.

Test Plan:
- Reset release, mem_ready tied 1, lw (opcode 35) -> IDLE then FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB. reg_write=1 with mem_to_reg=1 in cycle 5 after FETCH; instr_done pulse; instr_count=1.
- sw (43) with mem_ready low for 3 cycles in MEM_WRITE -> mem_write=1 held 4 cycles, iord=1 throughout; a single instr_done pulse.
- Sequence R-type(0), addi(8), beq(4) with mem_ready=1 -> 4, 4 and 3 cycles respectively. reg_dst=1 only in ALU_WB; pc_write_cond=1 with alu_op=01 in BRANCH; instr_count=3.
- Opcode 63 -> HALT after DECODE; illegal_op=1 and all controls 0 for 20+ cycles; rst then clears illegal_op and the FSM refetches.
- rst asserted during a MEM_READ stall -> outputs 0 asynchronously, state IDLE, instr_count=0, no reg_write afterwards.
- With MC_JUMP_EN, opcode 2 -> pc_write=1 and pc_source=10 in cycle 3; without the macro the same opcode sets illegal_op.
- With CNT_W=4 and 16 addi instructions -> instr_count wraps 15 to 0.
